// File: rtl/skid_fifo_writer_pkg.sv
// State encoding shared by the skid_fifo_writer write-side adapter.
package skid_fifo_writer_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;
endpackage

// File: rtl/skid_fifo_writer.sv
// Valid/ready stream to FIFO write-port adapter. A two-entry skid buffer keeps
// s_ready a pure flop, so upstream timing never sees the FIFO's full flag.
module skid_fifo_writer
  import skid_fifo_writer_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [DWIDTH-1:0]    s_data,
  output logic                 s_ready,
  input  logic                 flush,
  input  logic                 fifo_full,
  output logic                 fifo_write,
  output logic [DWIDTH-1:0]    fifo_din,
  output logic [CNT_WIDTH-1:0] word_count
);
  state_e               state_q, state_d;
  logic [DWIDTH-1:0]    out_data_q, out_data_d;
  logic [DWIDTH-1:0]    skid_data_q, skid_data_d;
  logic                 s_ready_q, s_ready_d;
  logic [CNT_WIDTH-1:0] word_count_q, word_count_d;
  logic                 accept, drain;

  assign accept     = s_valid & s_ready_q;
  // Combinational on fifo_full so a released FIFO is written in the same cycle.
  assign drain      = (state_q != ST_EMPTY) & ~fifo_full & ~flush;
  assign fifo_write = drain;
  assign fifo_din   = out_data_q;
  assign s_ready    = s_ready_q;
  assign word_count = word_count_q;

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    skid_data_d  = skid_data_q;
    word_count_d = word_count_q + CNT_WIDTH'(drain);
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d    = ST_ONE;
          out_data_d = s_data;
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_data_d = s_data;
          end else if (accept) begin
            state_d     = ST_TWO;
            skid_data_d = s_data;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: if (drain) begin
          state_d    = ST_ONE;
          out_data_d = skid_data_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    s_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      out_data_q   <= '0;
      skid_data_q  <= '0;
      s_ready_q    <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
      s_ready_q    <= s_ready_d;
      word_count_q <= word_count_d;
    end
  end
endmodule

// File: tb/tb_skid_fifo_writer.sv
// Bench for skid_fifo_writer: a queue of accepted beats models the buffer;
// every cycle checks write strobe, write data, ready and the word count.
module tb_skid_fifo_writer;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          flush = 1'b0;
  logic          fifo_full = 1'b0;
  logic          fifo_write;
  logic [DW-1:0] fifo_din;
  logic [CW-1:0] word_count;

  skid_fifo_writer #(.DWIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .flush(flush), .fifo_full(fifo_full), .fifo_write(fifo_write),
    .fifo_din(fifo_din), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [DW-1:0] q[$];
  logic [CW-1:0] mcount = '0;
  logic          mready = 1'b0;
  logic          last_acc;
  logic          last_wr;
  int unsigned   bad_wr_full = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mcount = '0;
    mready = 1'b0;
  endtask

  // One clock: inputs already driven; check, clock, update model.
  task automatic step();
    logic          acc, wr, fl;
    logic [DW-1:0] d;
    logic          exp_wr;
    #1;
    exp_wr = (q.size() > 0) && !fifo_full && !flush;
    chk("s_ready", s_ready, mready);
    chk("fifo_write", fifo_write, exp_wr);
    chk("word_count", word_count, mcount);
    if (fifo_write && fifo_full) bad_wr_full++;
    if (exp_wr && fifo_write) chk("fifo_din", fifo_din, q[0]);
    acc = s_valid && mready;
    wr  = exp_wr;
    fl  = flush;
    d   = s_data;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (wr) begin void'(q.pop_front()); mcount++; end
      if (acc) q.push_back(d);
    end
    mready   = (q.size() < 2);
    last_acc = acc;
    last_wr  = wr;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0; flush = 1'b0; fifo_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] nxt;
    logic [CW-1:0] saved;
    int            acc_cnt;
    int unsigned   sent;

    // Reset values and first stream 0x01..0x08.
    model_reset();
    #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_fifo_write", fifo_write, 1'b0);
    chk("rst_fifo_din", fifo_din, 32'h0);
    chk("rst_word_count", word_count, 16'h0);
    chk("rst_skid", dut.skid_data_q, 32'h0);
    do_reset();
    nxt = 32'h1;
    for (int c = 0; c < 40 && nxt <= 32'h8; c++) begin
      s_valid = 1'b1; s_data = nxt;
      step();
      if (c == 0) chk("ready_after_release", s_ready, 1'b1);
      if (last_acc) nxt++;
    end
    s_valid = 1'b0;
    repeat (3) step();
    chk("stream8_count", word_count, 16'd8);
    chk("stream8_drained", q.size(), 0);

    // Continuous stream with a 4-cycle full stall.
    nxt = 32'h100;
    for (int c = 0; c < 6; c++) begin
      s_valid = 1'b1; s_data = nxt; step();
      if (last_acc) nxt++;
    end
    fifo_full = 1'b1;
    acc_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      s_data = nxt; step();
      if (last_acc) begin nxt++; acc_cnt++; end
      if (c > 0) chk("stall_no_ready", s_ready, 1'b0);
      chk("stall_no_write", last_wr, 1'b0);
    end
    chk("stall_extra_beats", acc_cnt, 1);
    fifo_full = 1'b0;
    for (int c = 0; c < 10; c++) begin
      s_data = nxt; step();
      if (last_acc) nxt++;
    end
    s_valid = 1'b0;
    repeat (3) step();

    // Flush while holding two beats, with a beat offered.
    fifo_full = 1'b1; s_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin s_data = 32'hA0 + c; step(); end
    chk("pre_flush_full_two", s_ready, 1'b0);
    saved = word_count;
    flush = 1'b1; fifo_full = 1'b0; s_data = 32'hDEAD;
    step();
    flush = 1'b0; s_valid = 1'b0;
    chk("flush_ready", s_ready, 1'b1);
    chk("flush_count", word_count, saved);
    step();
    chk("flush_empty_no_write", last_wr, 1'b0);

    // Random traffic against the queue model.
    nxt = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      fifo_full = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 99) == 0);
      s_data    = nxt;
      step();
      if (last_acc) nxt++;
    end
    flush = 1'b0; fifo_full = 1'b0; s_valid = 1'b0;
    repeat (3) step();
    chk("rand_drained", q.size(), 0);
    chk("never_write_when_full", bad_wr_full, 0);

    // Async reset while holding two beats.
    fifo_full = 1'b1; s_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin s_data = 32'hB0 + c; step(); end
    #2;
    rst = 1'b1;
    #1;
    chk("async_s_ready", s_ready, 1'b0);
    chk("async_fifo_write", fifo_write, 1'b0);
    chk("async_fifo_din", fifo_din, 32'h0);
    chk("async_word_count", word_count, 16'h0);
    model_reset();
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nxt = 32'h50;
    for (int c = 0; c < 20 && nxt < 32'h54; c++) begin
      s_data = nxt; step();
      if (last_acc) nxt++;
    end
    s_valid = 1'b0;
    repeat (3) step();
    chk("post_reset_count", word_count, 16'd4);

    // Counter wrap: 65534 words, then 3 more.
    do_reset();
    sent = 0;
    for (int c = 0; c < 66000 && sent < 65534; c++) begin
      s_valid = 1'b1; s_data = sent; step();
      if (last_acc) sent++;
    end
    chk("wrap_sent", sent, 65534);
    s_valid = 1'b0;
    repeat (3) step();
    chk("wrap_fffe", word_count, 16'hFFFE);
    for (int c = 0; c < 20 && sent < 65537; c++) begin
      s_valid = 1'b1; s_data = sent; step();
      if (last_acc) sent++;
    end
    s_valid = 1'b0;
    repeat (3) step();
    chk("wrap_0001", word_count, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
